// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the five-stage sequencer and its stage units.
// The sequencer takes the slave side; the stage units/controller take the master side.
interface stage_sequencer_if;
    logic        start;
    logic        fetch_en,    decode_en,    exec_en,    mem_en,    wb_en;
    logic        fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready;
    logic [3:0]  op;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [2:0]  fault_stage;
    logic [15:0] instr_count;

    modport master (
        output start, fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready, op,
        input  fetch_en, decode_en, exec_en, mem_en, wb_en,
               busy, halted, fault, fault_stage, instr_count
    );

    modport slave (
        input  start, fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready, op,
        output fetch_en, decode_en, exec_en, mem_en, wb_en,
               busy, halted, fault, fault_stage, instr_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with per-stage ready timeout.
// All outputs are registered and decoded from the next state, so they line up with the state register.
module stage_sequencer #(
    parameter logic [3:0] OP_LOD  = 4'b0001,
    parameter logic [3:0] OP_STR  = 4'b0010,
    parameter logic [3:0] OP_HLT  = 4'b1111,
    parameter int         TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    stage_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_op_q;
    logic [15:0]   r_icnt;
    logic [2:0]    r_fstage;
    logic          r_fetch_en, r_decode_en, r_exec_en, r_mem_en, r_wb_en;
    logic          r_busy, r_halted, r_fault;
    logic          w_rdy;
    logic          w_tmo;

    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            S_FETCH:  w_rdy = bus.fetch_ready;
            S_DECODE: w_rdy = bus.decode_ready;
            S_EXEC:   w_rdy = bus.exec_ready;
            S_MEM:    w_rdy = bus.mem_ready;
            S_WB:     w_rdy = bus.wb_ready;
            default:  w_rdy = 1'b0;
        endcase
    end

    // r_cnt holds (cycles already spent in the state - 1); ready beats the timeout.
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_nxt = S_FETCH;
            S_FETCH:  if (w_rdy) w_nxt = S_DECODE;
                      else if (w_tmo) w_nxt = S_FAULT;
            S_DECODE: if (w_rdy) w_nxt = (bus.op == OP_HLT) ? S_HALT : S_EXEC;
                      else if (w_tmo) w_nxt = S_FAULT;
            S_EXEC:   if (w_rdy) w_nxt = (r_op_q == OP_LOD || r_op_q == OP_STR) ? S_MEM : S_WB;
                      else if (w_tmo) w_nxt = S_FAULT;
            S_MEM:    if (w_rdy) w_nxt = S_WB;
                      else if (w_tmo) w_nxt = S_FAULT;
            S_WB:     if (w_rdy) w_nxt = S_FETCH;
                      else if (w_tmo) w_nxt = S_FAULT;
            default:  w_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_q      <= '0;
            r_icnt      <= '0;
            r_fstage    <= '0;
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_wb_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            // A stage state is only held while r_cnt < TIMEOUT-1, so the increment never wraps.
            if (w_nxt != r_state || r_state == S_IDLE || r_state == S_HALT || r_state == S_FAULT)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_DECODE && w_rdy) r_op_q <= bus.op;
            if (r_state == S_WB && w_rdy)     r_icnt <= r_icnt + 16'd1;
            // Stage state encodings equal their fault codes.
            if (w_nxt == S_FAULT && r_state != S_FAULT) r_fstage <= r_state;

            r_fetch_en  <= (w_nxt == S_FETCH);
            r_decode_en <= (w_nxt == S_DECODE);
            r_exec_en   <= (w_nxt == S_EXEC);
            r_mem_en    <= (w_nxt == S_MEM);
            r_wb_en     <= (w_nxt == S_WB);
            r_busy      <= (w_nxt == S_FETCH) || (w_nxt == S_DECODE) || (w_nxt == S_EXEC) ||
                           (w_nxt == S_MEM)   || (w_nxt == S_WB);
            r_halted    <= (w_nxt == S_HALT);
            r_fault     <= (w_nxt == S_FAULT);
        end
    end

    assign bus.fetch_en    = r_fetch_en;
    assign bus.decode_en   = r_decode_en;
    assign bus.exec_en     = r_exec_en;
    assign bus.mem_en      = r_mem_en;
    assign bus.wb_en       = r_wb_en;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
    assign bus.fault_stage = r_fstage;
    assign bus.instr_count = r_icnt;
endmodule
